// File: rtl/lsu_mem_stage_if.sv
// Bundle of the request, dmemory and response signals of the MEM-stage
// load/store unit. The unit itself uses the slave view; whoever feeds it
// requests, models dmemory and drains responses uses the master view.
interface lsu_mem_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [4:0]        req_rd;

    logic [ADDR_W-1:0] dmem_address;
    logic              dmem_read_write;
    logic [1:0]        dmem_access_size;
    logic [DATA_W-1:0] dmem_data_in;
    logic [DATA_W-1:0] dmem_data_out;

    logic              resp_valid;
    logic              resp_ready;
    logic [4:0]        resp_rd;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_fault;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  dmem_data_out, resp_ready,
        output req_ready,
        output dmem_address, dmem_read_write, dmem_access_size, dmem_data_in,
        output resp_valid, resp_rd, resp_rdata, resp_fault
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output dmem_data_out, resp_ready,
        input  req_ready,
        input  dmem_address, dmem_read_write, dmem_access_size, dmem_data_in,
        input  resp_valid, resp_rd, resp_rdata, resp_fault
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit in front of dmemory. One request at a time:
// IDLE accepts, ISSUE drives dmemory for one cycle, WAIT captures load data,
// RESP holds the result until the writeback side takes it. Misaligned,
// illegal or out-of-window requests skip memory and go straight to RESP.
module lsu_mem_stage #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(32'h0100_0000)
) (
    input logic            clk,
    input logic            rst,
    lsu_mem_stage_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    state_t     next_state;
    logic       we_q;
    logic [2:0] funct3_q;
    logic [4:0] rd_q;
    logic       req_fault;

    // Illegal funct3 (load 3/6/7, store 3..7), misalignment, or below the window.
    function automatic logic is_fault(input logic we, input logic [2:0] f3,
                                      input logic [ADDR_W-1:0] addr);
        logic illegal;
        logic misaligned;
        illegal    = we ? (f3[2] || (f3[1:0] == 2'b11))
                        : ((f3[1:0] == 2'b11) || (f3[2:1] == 2'b11));
        misaligned = ((f3[1:0] == 2'b01) && addr[0]) ||
                     ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        return illegal || misaligned || (addr < START_ADDR);
    endfunction

    // Store data is right-aligned; clear everything above the access size.
    function automatic logic [DATA_W-1:0] store_mask(input logic [1:0] size,
                                                     input logic [DATA_W-1:0] wdata);
        case (size)
            2'b00:   return {{(DATA_W-8){1'b0}}, wdata[7:0]};
            2'b01:   return {{(DATA_W-16){1'b0}}, wdata[15:0]};
            default: return wdata;
        endcase
    endfunction

    // Sign- or zero-extend the right-aligned dmemory word; upper garbage is dropped.
    function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] f3,
                                                      input logic [DATA_W-1:0] raw);
        logic signed [DATA_W-1:0] sval;
        case (f3)
            3'b000:  sval = DATA_W'($signed(raw[7:0]));
            3'b001:  sval = DATA_W'($signed(raw[15:0]));
            3'b100:  sval = $signed({{(DATA_W-8){1'b0}}, raw[7:0]});
            3'b101:  sval = $signed({{(DATA_W-16){1'b0}}, raw[15:0]});
            default: sval = $signed(raw);
        endcase
        return sval;
    endfunction

    assign req_fault = is_fault(bus.req_we, bus.req_funct3, bus.req_addr);

    // State register; reset drops straight back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next state plus the handshake and write strobe, all decoded from state so reset clears them at once.
    always_comb begin
        next_state           = state;
        bus.req_ready        = 1'b0;
        bus.resp_valid       = 1'b0;
        bus.dmem_read_write  = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) next_state = req_fault ? RESP : ISSUE;
            end
            ISSUE: begin
                bus.dmem_read_write = we_q;
                next_state          = we_q ? RESP : WAIT;
            end
            WAIT:    next_state = RESP;
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Latch the request, drive dmemory address/size/data, and build the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q                 <= 1'b0;
            funct3_q             <= 3'd0;
            rd_q                 <= 5'd0;
            bus.dmem_address     <= '0;
            bus.dmem_access_size <= 2'd0;
            bus.dmem_data_in     <= '0;
            bus.resp_rd          <= 5'd0;
            bus.resp_rdata       <= '0;
            bus.resp_fault       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        funct3_q <= bus.req_funct3;
                        rd_q     <= bus.req_rd;
                        if (req_fault) begin
                            bus.resp_rd    <= 5'd0;
                            bus.resp_rdata <= '0;
                            bus.resp_fault <= 1'b1;
                        end else begin
                            // Address and size only move on a real access, so they hold elsewhere.
                            bus.dmem_address     <= bus.req_addr;
                            bus.dmem_access_size <= bus.req_funct3[1:0];
                            if (bus.req_we)
                                bus.dmem_data_in <= store_mask(bus.req_funct3[1:0], bus.req_wdata);
                        end
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        bus.resp_rd    <= 5'd0;
                        bus.resp_rdata <= '0;
                        bus.resp_fault <= 1'b0;
                    end
                end
                WAIT: begin
                    bus.resp_rd    <= rd_q;
                    bus.resp_rdata <= load_extend(funct3_q, bus.dmem_data_out);
                    bus.resp_fault <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed load/store/fault/reset/backpressure steps
// followed by random requests, checked against a byte-level memory model.
module tb_lsu_mem_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    lsu_mem_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu_mem_stage #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .START_ADDR (32'h0100_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Physical dmemory written only by the DUT; reference memory written only by the model.
    logic [7:0] phys_mem [int unsigned];
    logic [7:0] ref_mem  [int unsigned];

    function automatic logic [7:0] phys_byte(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // dmemory: synchronous write, data_out registered one cycle, random junk above the access size.
    always @(posedge clk) begin : dmem_model
        logic [31:0] word;
        int          n;
        n = (bus.dmem_access_size == 2'd3) ? 4 : (1 << bus.dmem_access_size);
        if (bus.dmem_read_write)
            for (int i = 0; i < n; i++) phys_mem[bus.dmem_address + 32'(i)] = bus.dmem_data_in[8*i +: 8];
        word = $urandom;
        for (int i = 0; i < n; i++) word[8*i +: 8] = phys_byte(bus.dmem_address + 32'(i));
        bus.dmem_data_out <= word;
    end

    function automatic logic exp_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic legal;
        int   sz;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz    = 1 << (f3 % 4);
        return !legal || ((a % sz) != 0) || (a < 32'h0100_0000);
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
        longint unsigned v;
        int              n;
        n = 1 << (f3 % 4);
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(ref_byte(a + 32'(i))) << (8 * i));
        case (f3)
            3'd0:    return (v >= 128)   ? 32'(longint'(v) - 256)   : 32'(v);
            3'd1:    return (v >= 32768) ? 32'(longint'(v) - 65536) : 32'(v);
            default: return 32'(v);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request from IDLE through the response handshake, with 'hold' cycles of backpressure.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input int hold,
                          input string tag);
        logic        fault;
        logic        seen;
        int          exp_lat, lat, pulses, n;
        logic [31:0] erdata, ewdata, pa, pdin, rdata0;
        logic [4:0]  erd, rd0;
        logic [1:0]  psize;
        fault   = exp_fault(we, f3, a);
        n       = 1 << (f3 % 4);
        ewdata  = (n == 4) ? wd : (wd % (32'd1 << (8 * n)));
        exp_lat = fault ? 1 : (we ? 2 : 3);
        erd     = (fault || we) ? 5'd0 : rd;
        erdata  = (fault || we) ? 32'd0 : exp_load(f3, a);
        if (we && !fault)
            for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = ewdata[8*i +: 8];
        pa = 0; pdin = 0; psize = 0;

        @(negedge clk);
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_rd     = rd;
        bus.resp_ready = 1'b0;
        @(posedge clk);
        #1;
        // Keep junk valid on the request lines while the unit is busy.
        bus.req_addr   = $urandom;
        bus.req_we     = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));

        seen = 1'b0; pulses = 0; lat = 0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk);
            if (bus.dmem_read_write) begin
                pulses++;
                pa    = bus.dmem_address;
                psize = bus.dmem_access_size;
                pdin  = bus.dmem_data_in;
            end
            if (bus.resp_valid) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check({tag, ".resp_seen"}, 32'(seen), 32'd1);
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".fault"}, 32'(bus.resp_fault), 32'(fault));
        check({tag, ".rd"}, 32'(bus.resp_rd), 32'(erd));
        check({tag, ".rdata"}, bus.resp_rdata, erdata);
        check({tag, ".wr_pulses"}, 32'(pulses), (we && !fault) ? 32'd1 : 32'd0);
        if (we && !fault) begin
            check({tag, ".wr_addr"}, pa, a);
            check({tag, ".wr_size"}, 32'(psize), 32'(f3[1:0]));
            check({tag, ".wr_data"}, pdin, ewdata);
        end
        rd0    = bus.resp_rd;
        rdata0 = bus.resp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(bus.resp_valid), 32'd1);
            check({tag, ".hold_rd"}, 32'(bus.resp_rd), 32'(rd0));
            check({tag, ".hold_rdata"}, bus.resp_rdata, rdata0);
            check({tag, ".hold_req_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        check({tag, ".post_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, ".post_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_we;
        logic [2:0]  r_f3;
        logic [31:0] r_addr, r_wd;
        logic [4:0]  r_rd;
        int          r_hold;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_rd     = 5'd0;
        bus.resp_ready = 1'b0;
        rst            = 1'b1;

        repeat (2) @(negedge clk);
        check("rst.req_ready", 32'(bus.req_ready), 32'd1);
        check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst.resp_rd", 32'(bus.resp_rd), 32'd0);
        check("rst.resp_rdata", bus.resp_rdata, 32'd0);
        check("rst.resp_fault", 32'(bus.resp_fault), 32'd0);
        check("rst.dmem_address", bus.dmem_address, 32'd0);
        check("rst.dmem_rw", 32'(bus.dmem_read_write), 32'd0);
        check("rst.dmem_size", 32'(bus.dmem_access_size), 32'd0);
        check("rst.dmem_din", bus.dmem_data_in, 32'd0);
        rst = 1'b0;

        do_req(1'b1, 3'd2, 32'h0100_0000, 32'd21972, 5'd3, 0, "sw");
        do_req(1'b0, 3'd2, 32'h0100_0000, 32'd0, 5'd5, 0, "lw");
        check("lw.const_rdata", 32'(exp_load(3'd2, 32'h0100_0000)), 32'h0000_55D4);

        do_req(1'b1, 3'd0, 32'h0100_0003, 32'hABCD_EFF0, 5'd0, 0, "sb");
        do_req(1'b0, 3'd0, 32'h0100_0003, 32'd0, 5'd6, 0, "lb");
        do_req(1'b0, 3'd4, 32'h0100_0003, 32'd0, 5'd7, 0, "lbu");
        do_req(1'b1, 3'd1, 32'h0100_0002, 32'h1234_8001, 5'd0, 0, "sh");
        do_req(1'b0, 3'd1, 32'h0100_0002, 32'd0, 5'd8, 0, "lh");
        do_req(1'b0, 3'd5, 32'h0100_0002, 32'd0, 5'd9, 0, "lhu");

        do_req(1'b0, 3'd2, 32'h0100_0002, 32'd0, 5'd4, 0, "flt_lw_mis");
        do_req(1'b1, 3'd1, 32'h0100_0001, 32'hFFFF_FFFF, 5'd4, 0, "flt_sh_mis");
        do_req(1'b0, 3'd3, 32'h0100_0000, 32'd0, 5'd4, 0, "flt_f3");
        do_req(1'b0, 3'd2, 32'h00FF_FFFC, 32'd0, 5'd4, 0, "flt_window");

        do_req(1'b0, 3'd2, 32'h0100_0000, 32'd0, 5'd10, 5, "lw_bp");

        // Reset while a load sits in WAIT.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h0100_0000; bus.req_rd = 5'd7;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_wait.req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_wait.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_wait.dmem_rw", 32'(bus.dmem_read_write), 32'd0);
        check("rst_wait.resp_rd", 32'(bus.resp_rd), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset during a store ISSUE cycle kills the write strobe at once.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h0100_0F00; bus.req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        check("st_issue.dmem_rw", 32'(bus.dmem_read_write), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_issue.dmem_rw", 32'(bus.dmem_read_write), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_req(1'b0, 3'd2, 32'h0100_0000, 32'd0, 5'd11, 0, "lw_after_rst");

        for (int k = 0; k < 40; k++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_f3   = 3'($urandom_range(0, 7));
            r_addr = ($urandom_range(0, 7) == 0) ? 32'h00FF_FFF0 + 32'($urandom_range(0, 15))
                                                 : 32'h0100_0000 + 32'($urandom_range(0, 31));
            r_wd   = $urandom;
            r_rd   = 5'($urandom_range(1, 31));
            r_hold = $urandom_range(0, 3);
            do_req(r_we, r_f3, r_addr, r_wd, r_rd, r_hold, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
